// File: rtl/rptr_empty_fwft.sv
// Read-side controller of a dual-clock FIFO. It keeps the binary/Gray read pointer and the
// registered empty/almost-empty/level flags, and feeds a first-word-fall-through output register.
module rptr_empty_fwft #(
  parameter int ADDR_WIDTH    = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  rclk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wptr_sync,
  input  logic [DATA_WIDTH-1:0] rdata_mem,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  empty,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_THRESH = PW'(AEMPTY_THRESH);

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wbin_sync;
  logic [PW-1:0] level_next;
  logic          rinc;

  // A word is fetched whenever memory holds one and the output register is free or draining.
  always_comb begin
    rinc       = ~empty & (~dout_valid | dout_ready);
    rbin_next  = rbin + PW'(rinc);
    rgray_next = (rbin_next >> 1) ^ rbin_next;
  end

  // Gray to binary: every binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin_sync = '0;
    for (int i = 0; i < PW; i++) begin
      wbin_sync[i] = ^(wptr_sync >> i);
    end
    level_next = wbin_sync - rbin_next;
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      rbin   <= '0;
      rptr   <= '0;
      empty  <= 1'b1;
      aempty <= 1'b1;
      rlevel <= '0;
    end else begin
      rbin   <= rbin_next;
      rptr   <= rgray_next;
      empty  <= (rgray_next == wptr_sync);
      rlevel <= level_next;
      aempty <= (level_next <= AE_THRESH);
    end
  end

  // Handshake: the consumer takes dout on any rising edge that sees dout_valid=1 and
  // dout_ready=1. dout stays stable while dout_valid=1 and dout_ready=0. A fetch in the
  // same cycle as a take replaces the word with no bubble.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (rinc) begin
      dout       <= rdata_mem;
      dout_valid <= 1'b1;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  assign raddr = rbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Bench for rptr_empty_fwft: a word-count model of the read side, a per-cycle compare,
// a dout scoreboard, and directed scenarios with hand-computed literal expectations.
module tb_rptr_empty_fwft;

  localparam int DW = 8;
  localparam int PW = 4;

  // clock / reset
  logic          rclk = 1'b0;
  logic          rst_n = 1'b1;
  logic [PW-1:0] wptr_sync = '0;
  logic [DW-1:0] rdata_mem;
  logic [2:0]    raddr;
  logic [PW-1:0] rptr;
  logic          empty;
  logic          aempty;
  logic [PW-1:0] rlevel;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;

  always #5 rclk = ~rclk;

  logic [DW-1:0] mem [8];
  assign rdata_mem = mem[raddr];

  rptr_empty_fwft #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .AEMPTY_THRESH(1)) dut (
    .rclk       (rclk),
    .rst_n      (rst_n),
    .wptr_sync  (wptr_sync),
    .rdata_mem  (rdata_mem),
    .raddr      (raddr),
    .rptr       (rptr),
    .empty      (empty),
    .aempty     (aempty),
    .rlevel     (rlevel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  int tests = 0;
  int fails = 0;
  int wcount = 0;
  logic [DW-1:0] exp_q[$];
  bit chk_en = 1'b0;
  bit pin_gray = 1'b0;
  logic [3:0] gray_tab [9] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                               4'b0111, 4'b0101, 4'b0100, 4'b1100};

  function automatic logic [3:0] to_gray(int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  function automatic int g2b(logic [3:0] g);
    logic [3:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    return int'(b);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model in words: m_rcnt words fetched so far, m_level words seen but not yet fetched.
  int            m_rcnt;
  int            m_level;
  bit            m_valid;
  bit            m_fetch;
  logic [DW-1:0] m_dout;

  always @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      m_rcnt  = 0;
      m_level = 0;
      m_valid = 1'b0;
      m_dout  = '0;
    end else begin
      m_fetch = (m_level != 0) && (!m_valid || dout_ready);
      if (m_fetch) begin
        m_dout  = mem[m_rcnt % 8];
        m_valid = 1'b1;
        m_rcnt++;
      end else if (dout_ready) begin
        m_valid = 1'b0;
      end
      m_level = (g2b(wptr_sync) - m_rcnt) & 15;
    end
  end

  // Per-cycle compare plus dout scoreboard on accepted words.
  always @(negedge rclk) begin
    if (chk_en) begin
      check("raddr",      32'(raddr),      32'(m_rcnt % 8));
      check("rptr",       32'(rptr),       32'(to_gray(m_rcnt % 16)));
      check("rlevel",     32'(rlevel),     32'(m_level));
      check("empty",      32'(empty),      32'(m_level == 0));
      check("aempty",     32'(aempty),     32'(m_level <= 1));
      check("dout_valid", 32'(dout_valid), 32'(m_valid));
      if (m_valid) check("dout", 32'(dout), 32'(m_dout));
      if (pin_gray && m_rcnt < 9) check("rptr_table", 32'(rptr), 32'(gray_tab[m_rcnt]));
      if (rst_n && dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_extra: got word %0h, want none at %0t", dout, $time);
        end else begin
          check("sb_dout", 32'(dout), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge rclk);
    #2;
  endtask

  task automatic write_word(logic [DW-1:0] val);
    mem[wcount % 8] = val;
    exp_q.push_back(val);
    wcount++;
    wptr_sync = to_gray(wcount % 16);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wcount = 0;
    wptr_sync = '0;
    dout_ready = 1'b0;
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;

    // reset with a nonzero write pointer held at the input
    #1;
    wptr_sync = 4'b0101;
    rst_n = 1'b0;
    #1;
    chk_en = 1'b1;
    check("rst_rptr",   32'(rptr),       32'h0);
    check("rst_raddr",  32'(raddr),      32'h0);
    check("rst_empty",  32'(empty),      32'h1);
    check("rst_aempty", 32'(aempty),     32'h1);
    check("rst_rlevel", 32'(rlevel),     32'h0);
    check("rst_valid",  32'(dout_valid), 32'h0);
    check("rst_dout",   32'(dout),       32'h0);
    step();
    step();
    wptr_sync = '0;
    rst_n = 1'b1;
    step();

    // single word, ready held high
    dout_ready = 1'b1;
    write_word(8'hA5);
    step();
    check("t2_empty_fall", 32'(empty), 32'h0);
    step();
    check("t2_valid", 32'(dout_valid), 32'h1);
    check("t2_dout",  32'(dout),       32'hA5);
    check("t2_raddr", 32'(raddr),      32'h1);
    check("t2_rptr",  32'(rptr),       32'b0001);
    check("t2_empty", 32'(empty),      32'h1);
    step();
    check("t2_valid_drop", 32'(dout_valid), 32'h0);

    // backpressure with three words
    do_reset();
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    step();
    step();
    check("t3_first", 32'(dout), 32'h11);
    step();
    step();
    check("t3_hold_dout",  32'(dout),   32'h11);
    check("t3_hold_raddr", 32'(raddr),  32'h1);
    check("t3_rlevel",     32'(rlevel), 32'h2);
    check("t3_aempty",     32'(aempty), 32'h0);
    dout_ready = 1'b1;
    step();
    check("t3_word1", 32'(dout), 32'h22);
    step();
    check("t3_word2",  32'(dout),   32'h33);
    check("t3_empty",  32'(empty),  32'h1);
    check("t3_rlevel0", 32'(rlevel), 32'h0);
    check("t3_aempty1", 32'(aempty), 32'h1);
    step();
    check("t3_valid_drop", 32'(dout_valid), 32'h0);

    // streaming 20 words through a wrap
    do_reset();
    dout_ready = 1'b1;
    pin_gray = 1'b1;
    for (int i = 0; i < 45; i++) begin
      if (wcount < 20 && (wcount - m_rcnt) < 8) write_word(8'(wcount));
      step();
    end
    pin_gray = 1'b0;
    check("t4_all_delivered", 32'(exp_q.size()), 32'h0);
    check("t4_rptr",  32'(rptr),  32'b0110);
    check("t4_raddr", 32'(raddr), 32'h4);
    check("t4_empty", 32'(empty), 32'h1);

    // full memory then drain
    do_reset();
    for (int i = 0; i < 8; i++) write_word(8'(8'hC0 + i));
    step();
    check("t5_rlevel8", 32'(rlevel), 32'h8);
    check("t5_empty",   32'(empty),  32'h0);
    check("t5_aempty",  32'(aempty), 32'h0);
    dout_ready = 1'b1;
    repeat (10) step();
    check("t5_rlevel0", 32'(rlevel), 32'h0);
    check("t5_rptr",    32'(rptr),   32'b1100);
    check("t5_empty1",  32'(empty),  32'h1);

    // reset while a word is held under backpressure
    do_reset();
    write_word(8'h5A);
    write_word(8'h6B);
    write_word(8'h7C);
    repeat (3) step();
    check("t6_held", 32'(dout_valid), 32'h1);
    #1;
    rst_n = 1'b0;
    wcount = 0;
    wptr_sync = '0;
    exp_q.delete();
    #1;
    check("t6_valid_async", 32'(dout_valid), 32'h0);
    check("t6_rptr_async",  32'(rptr),       32'h0);
    check("t6_raddr_async", 32'(raddr),      32'h0);
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("t6_empty_after", 32'(empty),      32'h1);
    check("t6_valid_after", 32'(dout_valid), 32'h0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
